// File: rtl/alu_operand_sel_stage.sv
// alu_operand_sel_stage
//   Registered operand selector feeding the ALU B port. One of NUM_SRC data
//   words or the constant CONST_VAL is chosen by sel. The chosen word is then
//   held in a two-entry valid/ready skid buffer, so the control unit can stall
//   the ALU without dropping an operand. An out-of-range select re-issues the
//   last legal operand and latches a sticky error flag.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high; empties the stage and clears all state
//   src_flat   packed sources, source i = src_flat[i*WIDTH +: WIDTH]
//   sel        source select, sampled when in_valid & in_ready
//   in_valid   upstream offers sel/src this cycle
//   in_ready   stage can accept (decoded from registered state only)
//   out_data   registered selected operand
//   out_valid  out_data holds an operand
//   out_ready  ALU consumes out_data this cycle
//   err_clr    clears sel_err (loses to a simultaneous new error)
//   sel_err    sticky flag: an out-of-range sel was accepted
module alu_operand_sel_stage #(
  parameter int WIDTH     = 32,
  parameter int NUM_SRC   = 5,
  parameter int SEL_W     = 3,
  parameter int CONST_SEL = 3,
  parameter int CONST_VAL = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SRC*WIDTH-1:0] src_flat,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     err_clr,
  output logic                     sel_err
);

  localparam logic [WIDTH-1:0] CONST_W = WIDTH'(CONST_VAL);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] main_q, skid_q, last_legal_q;
  logic             in_ready_q, sel_err_q;
  logic [WIDTH-1:0] pick;
  logic             pick_legal;
  logic             accept, pop;
  logic             load_main_new, load_main_skid, load_skid;

  assign accept    = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign in_ready  = in_ready_q;
  assign sel_err   = sel_err_q;

  // Operand select. The constant occupies code CONST_SEL and the data
  // sources fill the remaining codes in ascending order, so sources at or
  // above CONST_SEL are shifted up by one code. Any code that matches
  // nothing falls back to the last legal operand.
  always_comb begin
    pick       = last_legal_q;
    pick_legal = 1'b0;
    if (32'(sel) == CONST_SEL) begin
      pick       = CONST_W;
      pick_legal = 1'b1;
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (32'(sel) == ((i < CONST_SEL) ? i : i + 1)) begin
        pick       = src_flat[i*WIDTH +: WIDTH];
        pick_legal = 1'b1;
      end
    end
  end

  // Skid-buffer control. Occupancy is tracked as EMPTY/ONE/TWO. The main
  // register always holds the oldest entry. The skid register absorbs one
  // extra accept while the ALU is stalled. Accepts in TWO and pops in EMPTY
  // cannot occur, because in_ready and out_valid are decoded from state.
  always_comb begin
    state_next     = state;
    load_main_new  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_next    = ONE;
          load_main_new = 1'b1;
        end
      end
      ONE: begin
        if (accept && pop) begin
          load_main_new = 1'b1;
        end else if (accept) begin
          state_next = TWO;
          load_skid  = 1'b1;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_next     = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // State register and the registered in_ready. in_ready comes from the
  // next state, so it never depends combinationally on out_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_next;
      in_ready_q <= (state_next != TWO);
    end
  end

  // Data storage, last-legal tracking and the sticky error flag. A new
  // error in the same cycle takes priority over err_clr, so an error is
  // never silently lost. out_data is not cleared when the stage drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_q       <= '0;
      skid_q       <= '0;
      last_legal_q <= '0;
      sel_err_q    <= 1'b0;
    end else begin
      if (load_main_new) begin
        main_q <= pick;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= pick;
      end
      if (accept && pick_legal) begin
        last_legal_q <= pick;
      end
      if (accept && !pick_legal) begin
        sel_err_q <= 1'b1;
      end else if (err_clr) begin
        sel_err_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_sel_stage.sv
// tb_alu_operand_sel_stage
//   Directed and random stimulus for alu_operand_sel_stage. A bench-side
//   model keeps a queue of expected operands together with the expected
//   flags. DUT outputs are compared on the falling edge.
module tb_alu_operand_sel_stage;

  localparam int W  = 32;
  localparam int N  = 5;
  localparam int SW = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid, out_ready, err_clr;
  logic [SW-1:0]  sel;
  logic [W-1:0]   src [N];
  logic [N*W-1:0] src_flat;
  logic           in_ready, out_valid, sel_err;
  logic [W-1:0]   out_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] sb_q [$];
  logic [W-1:0] last_m, hold_m;
  logic         err_m;

  assign src_flat = {src[4], src[3], src[2], src[1], src[0]};

  alu_operand_sel_stage dut (
    .clk       (clk),
    .reset     (reset),
    .src_flat  (src_flat),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_clr   (err_clr),
    .sel_err   (sel_err)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  // Reference code map: 3 selects the constant 4, codes 0..2 select
  // sources 0..2, codes 4..5 select sources 3..4, and any other code
  // returns the last legal operand.
  function automatic logic [W-1:0] refPick(input logic [SW-1:0] s);
    case (s)
      3'd0:    return src[0];
      3'd1:    return src[1];
      3'd2:    return src[2];
      3'd3:    return 32'd4;
      3'd4:    return src[3];
      3'd5:    return src[4];
      default: return last_m;
    endcase
  endfunction

  // Compare one observed value against its expected value.
  task automatic checkValue(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output against the model state.
  task automatic checkOutput();
    checkValue("out_valid", W'(out_valid), W'(sb_q.size() > 0));
    checkValue("in_ready",  W'(in_ready),  W'(sb_q.size() < 2));
    checkValue("out_data",  out_data, (sb_q.size() > 0) ? sb_q[0] : hold_m);
    checkValue("sel_err",   W'(sel_err),   W'(err_m));
  endtask

  // Drive one cycle of inputs, then update the model at the rising edge.
  // Check the outputs on the following falling edge.
  task automatic applyStimulus(input logic v, input logic [SW-1:0] s, input logic ordy,
                               input logic clr, input logic rst);
    logic         acc, pp, legal;
    logic [W-1:0] val;
    in_valid  = v;
    sel       = s;
    out_ready = ordy;
    err_clr   = clr;
    reset     = rst;
    @(posedge clk);
    if (rst) begin
      sb_q.delete();
      err_m  = 1'b0;
      last_m = '0;
      hold_m = '0;
    end else begin
      acc   = v && (sb_q.size() < 2);
      pp    = (sb_q.size() > 0) && ordy;
      val   = refPick(s);
      legal = (s <= 3'd5);
      if (pp) void'(sb_q.pop_front());
      if (acc) begin
        sb_q.push_back(val);
        if (legal) last_m = val;
      end
      if (acc && !legal) err_m = 1'b1;
      else if (clr)      err_m = 1'b0;
      if (sb_q.size() > 0) hold_m = sb_q[0];
    end
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    for (int i = 0; i < N; i++) src[i] = W'(32'h100 + i);
    in_valid = 0; sel = '0; out_ready = 0; err_clr = 0; reset = 1;
    last_m = '0; hold_m = '0; err_m = 1'b0;

    $display("[TB] reset");
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(1, 3, 1, 0, 1);

    $display("[TB] constant select");
    applyStimulus(1, 3, 1, 0, 0);
    checkValue("t1_const", out_data, 32'd4);
    applyStimulus(0, 0, 1, 0, 0);

    $display("[TB] back-to-back sources");
    src[0] = 32'hAAAA0000; src[4] = 32'h12345678;
    applyStimulus(1, 0, 1, 0, 0);
    checkValue("t2_src0", out_data, 32'hAAAA0000);
    applyStimulus(1, 5, 1, 0, 0);
    checkValue("t2_src4", out_data, 32'h12345678);
    checkValue("t2_ready", W'(in_ready), 32'd1);
    applyStimulus(0, 0, 1, 0, 0);

    $display("[TB] stall and drain");
    src[0] = 32'h11; src[1] = 32'h22; src[2] = 32'h33;
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    checkValue("t3_full", W'(in_ready), 32'd0);
    applyStimulus(1, 2, 0, 0, 0);
    applyStimulus(1, 2, 1, 0, 0);
    checkValue("t3_first", out_data, 32'h22);
    applyStimulus(1, 2, 1, 0, 0);
    checkValue("t3_third", out_data, 32'h33);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);

    $display("[TB] illegal select");
    src[2] = 32'hBEEF;
    applyStimulus(1, 2, 1, 0, 0);
    applyStimulus(1, 7, 1, 0, 0);
    checkValue("t4_hold", out_data, 32'hBEEF);
    checkValue("t4_err", W'(sel_err), 32'd1);
    applyStimulus(1, 7, 1, 1, 0);
    checkValue("t4_setwins", W'(sel_err), 32'd1);
    applyStimulus(0, 0, 1, 1, 0);
    checkValue("t4_clr", W'(sel_err), 32'd0);

    $display("[TB] reset from full");
    applyStimulus(1, 7, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 0, 1, 1, 1);
    checkValue("t5_data", out_data, 32'd0);
    applyStimulus(1, 3, 1, 0, 0);
    checkValue("t5_const", out_data, 32'd4);

    $display("[TB] random traffic");
    for (int c = 0; c < 12000; c++) begin
      for (int i = 0; i < N; i++) src[i] = $urandom;
      applyStimulus(1'($urandom_range(0, 3) != 0), SW'($urandom_range(0, 7)),
                    1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 7) == 0),
                    1'($urandom_range(0, 999) == 0));
    end
    for (int c = 0; c < 4; c++) applyStimulus(0, 0, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
